// File: rtl/conv_fprop1_mul_pkg.sv
// Width, result-type, rounding and saturation helpers shared by the conv_fprop1 multiplier.
// Optional accumulator feature is selected with the MUL_PIPE_ACC_EN macro.
package conv_fprop1_mul_pkg;

  // Internal arithmetic width; must exceed DIN0_WIDTH+DIN1_WIDTH+2 and DOUT_WIDTH+1.
  localparam int WIDE_W = 136;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic bit res_signed(input int s0, input int s1);
    return (s0 != 0) || (s1 != 0);
  endfunction

  function automatic wide_t sat_max(input int w, input bit s);
    wide_t one;
    one = wide_t'(1);
    return s ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic wide_t sat_min(input int w, input bit s);
    wide_t one;
    one = wide_t'(1);
    return s ? -(one <<< (w - 1)) : '0;
  endfunction

  // Half an output LSB, added before the arithmetic shift to round half up.
  function automatic wide_t rnd_const(input int shift);
    wide_t one;
    one = wide_t'(1);
    return (shift > 0) ? (one <<< (shift - 1)) : '0;
  endfunction

  function automatic wide_t clip(input wide_t v, input int w, input bit s, output bit hit);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi  = sat_max(w, s);
    lo  = sat_min(w, s);
    hit = (v > hi) || (v < lo);
    if (v > hi)      res = hi;
    else if (v < lo) res = lo;
    else             res = v;
    return res;
  endfunction

endpackage

// File: rtl/conv_fprop1_mul_lane.sv
// One multiplier lane: operand regs, multiply, product delay chain, round/saturate and
// (with MUL_PIPE_ACC_EN) a saturating accumulator that doubles as the output register.
module conv_fprop1_mul_lane
  import conv_fprop1_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 31,
  parameter int DIN1_WIDTH  = 32,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 2,
  parameter int SHIFT       = 0,
  parameter int DOUT_WIDTH  = 58
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [NUM_STAGE-1:0]  ld,
  input  logic                  clr,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int    P         = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int    IW        = P + 1;
  localparam bit    RS        = res_signed(DIN0_SIGNED, DIN1_SIGNED);
  localparam bit    NEED_CLIP = DOUT_WIDTH < P - SHIFT + 1;
  localparam wide_t RND       = rnd_const(SHIFT);

  logic [DIN0_WIDTH-1:0] a_q;
  logic [DIN1_WIDTH-1:0] b_q;

  // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ce && ld[0]) begin
      a_q <= din0;
      b_q <= din1;
    end
  end

  // One spare bit keeps unsigned x unsigned products positive in a signed multiply.
  logic signed [IW-1:0] a_x, b_x, p, p_fin;
  assign a_x = {{(IW-DIN0_WIDTH){(DIN0_SIGNED != 0) && a_q[DIN0_WIDTH-1]}}, a_q};
  assign b_x = {{(IW-DIN1_WIDTH){(DIN1_SIGNED != 0) && b_q[DIN1_WIDTH-1]}}, b_q};
  assign p   = a_x * b_x;

  if (NUM_STAGE == 2) begin : g_nodly
    assign p_fin = p;
  end else begin : g_dly
    logic signed [IW-1:0] dly [NUM_STAGE-2];
    // NOTE: the delay chain is a few pipeline flops, not a RAM, so it takes the async reset too.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < NUM_STAGE - 2; i++) dly[i] <= '0;
      end else if (ce) begin
        if (ld[1]) dly[0] <= p;
        for (int i = 1; i < NUM_STAGE - 2; i++) begin
          if (ld[i+1]) dly[i] <= dly[i-1];
        end
      end
    end
    assign p_fin = dly[NUM_STAGE-3];
  end

  wide_t                 p_w, r_w, y_w;
  logic                  hit_r;
  logic [DOUT_WIDTH-1:0] y_n;
  logic                  hit_n;
  logic                  unused_hi;

`ifdef MUL_PIPE_ACC_EN
  wide_t acc_w, sum_w, s_w;
  logic  hit_a;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit_r = 1'b0;
    p_w   = {{(WIDE_W-IW){p_fin[IW-1]}}, p_fin};
    r_w   = (p_w + RND) >>> SHIFT;
    if (NEED_CLIP) y_w = clip(r_w, DOUT_WIDTH, RS, hit_r);
    else           y_w = r_w;
`ifdef MUL_PIPE_ACC_EN
    hit_a = 1'b0;
    acc_w = {{(WIDE_W-DOUT_WIDTH){RS && dout[DOUT_WIDTH-1]}}, dout};
    sum_w = acc_w + y_w;
    s_w   = clip(sum_w, DOUT_WIDTH, RS, hit_a);
    if (clr) begin
      y_n   = y_w[DOUT_WIDTH-1:0];
      hit_n = hit_r;
    end else begin
      y_n   = s_w[DOUT_WIDTH-1:0];
      hit_n = hit_r | hit_a;
    end
`else
    y_n   = y_w[DOUT_WIDTH-1:0];
    hit_n = hit_r;
`endif
  end

`ifdef MUL_PIPE_ACC_EN
  assign unused_hi = ^{y_w, s_w};
`else
  assign unused_hi = ^{y_w, clr};
`endif

  // dout holds its last value between beats; sat_flag only lives for one out_valid beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout     <= '0;
      sat_flag <= 1'b0;
    end else if (ce) begin
      if (ld[NUM_STAGE-1]) begin
        dout     <= y_n;
        sat_flag <= hit_n;
      end else begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_fprop1_mul_pipe_sat.sv
// Multi-lane pipelined multiplier with round/saturate; shared valid (and acc_clr) pipe.
// Define MUL_PIPE_ACC_EN to add a per-lane saturating accumulator in the final stage.
module conv_fprop1_mul_pipe_sat
  import conv_fprop1_mul_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int DIN0_WIDTH  = 31,
  parameter int DIN1_WIDTH  = 32,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 2,
  parameter int SHIFT       = 0,
  parameter int DOUT_WIDTH  = 58
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic                        acc_clr,
  input  logic [LANES*DIN0_WIDTH-1:0] din0,
  input  logic [LANES*DIN1_WIDTH-1:0] din1,
  output logic                        out_valid,
  output logic [LANES*DOUT_WIDTH-1:0] dout,
  output logic [LANES-1:0]            sat_flag
);

  // vp[i] is the valid bit of stage i+1; ld[i] is the load enable of stage i+1.
  logic [NUM_STAGE-1:0] vp;
  logic [NUM_STAGE-1:0] ld;
  logic                 clr_fin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vp <= '0;
    else if (ce) vp <= {vp[NUM_STAGE-2:0], in_valid};
  end

  assign ld        = {vp[NUM_STAGE-2:0], in_valid};
  assign out_valid = vp[NUM_STAGE-1];

`ifdef MUL_PIPE_ACC_EN
  logic [NUM_STAGE-2:0] cp;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cp <= '0;
    end else if (ce) begin
      cp[0] <= acc_clr;
      for (int i = 1; i < NUM_STAGE - 1; i++) cp[i] <= cp[i-1];
    end
  end
  assign clr_fin = cp[NUM_STAGE-2];
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign clr_fin        = 1'b0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    conv_fprop1_mul_lane #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .DIN0_SIGNED(DIN0_SIGNED),
      .DIN1_SIGNED(DIN1_SIGNED),
      .NUM_STAGE  (NUM_STAGE),
      .SHIFT      (SHIFT),
      .DOUT_WIDTH (DOUT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .ld      (ld),
      .clr     (clr_fin),
      .din0    (din0[l*DIN0_WIDTH +: DIN0_WIDTH]),
      .din1    (din1[l*DIN1_WIDTH +: DIN1_WIDTH]),
      .dout    (dout[l*DOUT_WIDTH +: DOUT_WIDTH]),
      .sat_flag(sat_flag[l])
    );
  end

endmodule
